// File: rtl/line_window_ctrl.sv
// Streams KERNEL x KERNEL pixel windows out of a raster input.
// The line store is a ring of KERNEL+1 lines, so one line can fill while KERNEL lines are read.
module line_window_ctrl #(
  parameter int unsigned PIXEL_W   = 8,
  parameter int unsigned IMG_WIDTH = 256,
  parameter int unsigned KERNEL    = 3
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [PIXEL_W-1:0]                            pixel_in,
  input  logic                                          pixel_in_valid,
  output logic                                          pixel_in_ready,
  output logic [KERNEL*KERNEL*PIXEL_W-1:0]              pixel_out,
  output logic                                          pixel_out_valid,
  input  logic                                          pixel_out_ready,
  output logic                                          out_intr,
  output logic [$clog2((KERNEL+1)*IMG_WIDTH+1)-1:0]     fill_level
);

  localparam int unsigned NUM_LB = KERNEL + 1;
  localparam int unsigned CAP    = NUM_LB * IMG_WIDTH;
  localparam int unsigned FILL_W = $clog2(CAP + 1);
  localparam int unsigned COL_W  = $clog2(IMG_WIDTH);
  localparam int unsigned LB_W   = $clog2(NUM_LB);
  localparam int unsigned LBS_W  = LB_W + 1;
  localparam int unsigned WIN_W  = KERNEL * KERNEL * PIXEL_W;

  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(IMG_WIDTH - KERNEL);
  localparam logic [COL_W-1:0]  MAX_COL  = COL_W'(IMG_WIDTH - 1);
  localparam logic [LB_W-1:0]   MAX_LB   = LB_W'(NUM_LB - 1);
  localparam logic [FILL_W-1:0] CAP_F    = FILL_W'(CAP);
  localparam logic [FILL_W-1:0] START_F  = FILL_W'(KERNEL * IMG_WIDTH);
  localparam logic [FILL_W-1:0] ROW_F    = FILL_W'(IMG_WIDTH);

  typedef enum logic [1:0] {IDLE, LOAD, READ} state_t;

  logic [PIXEL_W-1:0] line_mem [NUM_LB][IMG_WIDTH];

  logic [LB_W-1:0]   wr_lb;
  logic [COL_W-1:0]  wr_col;
  logic [LB_W-1:0]   rd_lb,  rd_lb_d;
  logic [COL_W-1:0]  rd_col, rd_col_d;
  state_t            state,  state_d;
  logic              valid_d;
  logic              intr_d;
  logic              load_win;
  logic              release_row;
  logic [COL_W-1:0]  win_col;
  logic [WIN_W-1:0]  win_d;
  logic [LBS_W-1:0]  lb_sel;
  logic              accept;
  logic [FILL_W-1:0] fill_d;

  // Back-pressure only when every line still holds unreleased pixels.
  assign pixel_in_ready = (fill_level < CAP_F);
  assign accept         = pixel_in_valid && pixel_in_ready;

  always_comb begin
    fill_d = fill_level;
    if (accept) begin
      fill_d = fill_d + FILL_W'(1);
    end
    if (release_row) begin
      fill_d = fill_d - ROW_F;
    end
  end

  // Write pointer walks the ring line by line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_lb      <= '0;
      wr_col     <= '0;
      fill_level <= '0;
    end else begin
      fill_level <= fill_d;
      if (accept) begin
        if (wr_col == MAX_COL) begin
          wr_col <= '0;
          wr_lb  <= (wr_lb == MAX_LB) ? '0 : wr_lb + LB_W'(1);
        end else begin
          wr_col <= wr_col + COL_W'(1);
        end
      end
    end
  end

  // Line storage is intentionally not reset; it is always rewritten before it is read.
  always_ff @(posedge clk) begin
    if (accept) begin
      line_mem[wr_lb][wr_col] <= pixel_in;
    end
  end

  // Read-side next state and next registered outputs.
  always_comb begin
    state_d     = state;
    rd_lb_d     = rd_lb;
    rd_col_d    = rd_col;
    valid_d     = pixel_out_valid;
    intr_d      = 1'b0;
    load_win    = 1'b0;
    release_row = 1'b0;
    win_col     = '0;
    unique case (state)
      IDLE: begin
        if (fill_level >= START_F) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        load_win = 1'b1;
        win_col  = '0;
        rd_col_d = '0;
        valid_d  = 1'b1;
        state_d  = READ;
      end
      READ: begin
        if (pixel_out_valid && pixel_out_ready) begin
          if (rd_col == LAST_COL) begin
            release_row = 1'b1;
            intr_d      = 1'b1;
            valid_d     = 1'b0;
            rd_col_d    = '0;
            rd_lb_d     = (rd_lb == MAX_LB) ? '0 : rd_lb + LB_W'(1);
            state_d     = IDLE;
          end else begin
            rd_col_d = rd_col + COL_W'(1);
            win_col  = rd_col + COL_W'(1);
            load_win = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Gather the window at win_col; row 0 is the oldest line and sits in the low slice.
  always_comb begin
    win_d  = '0;
    lb_sel = '0;
    for (int unsigned k = 0; k < KERNEL; k++) begin
      lb_sel = LBS_W'(rd_lb) + LBS_W'(k);
      if (lb_sel >= LBS_W'(NUM_LB)) begin
        lb_sel = lb_sel - LBS_W'(NUM_LB);
      end
      for (int unsigned j = 0; j < KERNEL; j++) begin
        win_d[(k*KERNEL+j)*PIXEL_W +: PIXEL_W] = line_mem[lb_sel[LB_W-1:0]][win_col + COL_W'(j)];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      rd_lb           <= '0;
      rd_col          <= '0;
      pixel_out_valid <= 1'b0;
      out_intr        <= 1'b0;
      pixel_out       <= '0;
    end else begin
      state           <= state_d;
      rd_lb           <= rd_lb_d;
      rd_col          <= rd_col_d;
      pixel_out_valid <= valid_d;
      out_intr        <= intr_d;
      if (load_win) begin
        pixel_out <= win_d;
      end
    end
  end

endmodule

// File: tb/tb_line_window_ctrl.sv
// Directed bench for line_window_ctrl: default geometry plus a KERNEL=5 / IMG_WIDTH=16 / PIXEL_W=10 instance.
module tb_line_window_ctrl;

  localparam int PW    = 8;
  localparam int W     = 256;
  localparam int K     = 3;
  localparam int WIN_W = K * K * PW;
  localparam int NWIN  = W - K + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [PW-1:0]    pixel_in;
  logic             pixel_in_valid;
  logic             pixel_in_ready;
  logic [WIN_W-1:0] pixel_out;
  logic             pixel_out_valid;
  logic             pixel_out_ready;
  logic             out_intr;
  logic [10:0]      fill_level;

  logic [9:0]       s_pixel_in;
  logic             s_in_valid;
  logic             s_in_ready;
  logic [249:0]     s_pixel_out;
  logic             s_out_valid;
  logic             s_out_ready;
  logic             s_intr;
  logic [6:0]       s_fill;

  int        total = 0;
  int        bad   = 0;
  int        pix_sent;
  int        row_out;
  int        nwin;
  logic [7:0] salt;

  line_window_ctrl #(.PIXEL_W(8), .IMG_WIDTH(256), .KERNEL(3)) dut (
    .clk(clk), .rst(rst),
    .pixel_in(pixel_in), .pixel_in_valid(pixel_in_valid), .pixel_in_ready(pixel_in_ready),
    .pixel_out(pixel_out), .pixel_out_valid(pixel_out_valid), .pixel_out_ready(pixel_out_ready),
    .out_intr(out_intr), .fill_level(fill_level)
  );

  line_window_ctrl #(.PIXEL_W(10), .IMG_WIDTH(16), .KERNEL(5)) dut_s (
    .clk(clk), .rst(rst),
    .pixel_in(s_pixel_in), .pixel_in_valid(s_in_valid), .pixel_in_ready(s_in_ready),
    .pixel_out(s_pixel_out), .pixel_out_valid(s_out_valid), .pixel_out_ready(s_out_ready),
    .out_intr(s_intr), .fill_level(s_fill)
  );

  function automatic logic [PW-1:0] pval(int r, int c, logic [7:0] s);
    return 8'(r * 16 + c) ^ s;
  endfunction

  function automatic logic [WIN_W-1:0] exp_win(int r, int c, logic [7:0] s);
    logic [WIN_W-1:0] w;
    w = '0;
    for (int k = 0; k < K; k++)
      for (int j = 0; j < K; j++)
        w[(k*K+j)*PW +: PW] = pval(r + k, c + j, s);
    return w;
  endfunction

  function automatic logic [9:0] sval(int n);
    return 10'((n / 16) * 37 + (n % 16) * 3 + 1);
  endfunction

  function automatic logic [249:0] exp_swin(int c);
    logic [249:0] w;
    w = '0;
    for (int k = 0; k < 5; k++)
      for (int j = 0; j < 5; j++)
        w[(k*5+j)*10 +: 10] = sval(k * 16 + c + j);
    return w;
  endfunction

  // One cycle of stimulus on the default instance; reports the handshakes taken at the next edge.
  task automatic drive_cycle(input logic iv, input logic orr, output logic acc, output logic xf);
    @(negedge clk);
    pixel_in        = pval(pix_sent / W, pix_sent % W, salt);
    pixel_in_valid  = iv;
    pixel_out_ready = orr;
    acc = iv && pixel_in_ready;
    xf  = pixel_out_valid && orr;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    pixel_in_valid = 1'b0; pixel_out_ready = 1'b0;
    s_in_valid = 1'b0; s_out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    pix_sent = 0; row_out = 0; nwin = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    pixel_in = '0; pixel_in_valid = 1'b1; pixel_out_ready = 1'b0;
    s_pixel_in = '0; s_in_valid = 1'b0; s_out_ready = 1'b0;
    pix_sent = 0; row_out = 0; nwin = 0; salt = 8'h00;
    repeat (3) @(negedge clk);
    total++; if (pixel_out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", pixel_out_valid); end
    total++; if (out_intr !== 1'b0) begin bad++; $display("FAIL rst_intr got=%b exp=0", out_intr); end
    total++; if (pixel_out !== '0) begin bad++; $display("FAIL rst_pixel_out got=%h exp=0", pixel_out); end
    total++; if (fill_level !== 11'd0) begin bad++; $display("FAIL rst_fill got=%0d exp=0", fill_level); end
    total++; if (pixel_in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", pixel_in_ready); end
    total++; if (dut.wr_col !== 8'd0) begin bad++; $display("FAIL rst_wr_col got=%0d exp=0", dut.wr_col); end
    pixel_in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic_fill();
    logic acc, xf;
    int cyc = 0, fill_cyc = -1, vld_cyc = -1, nintr = 0;
    logic [WIN_W-1:0] first_w = '0;
    salt = 8'h00; nwin = 0; row_out = 0;
    while (nwin < NWIN && cyc < 3000) begin
      drive_cycle(pix_sent < 3 * W, 1'b1, acc, xf);
      if (fill_cyc < 0 && fill_level == 11'd768) fill_cyc = cyc;
      if (vld_cyc < 0 && pixel_out_valid) vld_cyc = cyc;
      if (out_intr) nintr++;
      if (xf) begin
        if (nwin == 0) first_w = pixel_out;
        total++;
        if (pixel_out !== exp_win(row_out, nwin, salt)) begin
          bad++; $display("FAIL basic_win col=%0d got=%h exp=%h", nwin, pixel_out, exp_win(row_out, nwin, salt));
        end
        nwin++;
      end
      if (acc) pix_sent++;
      cyc++;
    end
    repeat (3) begin drive_cycle(1'b0, 1'b1, acc, xf); if (out_intr) nintr++; end
    total++; if (fill_cyc < 0 || vld_cyc - fill_cyc != 2) begin bad++; $display("FAIL basic_latency got=%0d exp=2", vld_cyc - fill_cyc); end
    total++; if (first_w !== 72'h222120121110020100) begin bad++; $display("FAIL basic_first got=%h exp=222120121110020100", first_w); end
    total++; if (nwin != NWIN) begin bad++; $display("FAIL basic_count got=%0d exp=%0d", nwin, NWIN); end
    total++; if (nintr != 1) begin bad++; $display("FAIL basic_intr got=%0d exp=1", nintr); end
    total++; if (fill_level !== 11'd512) begin bad++; $display("FAIL basic_fill got=%0d exp=512", fill_level); end
    total++; if (pixel_out_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_end got=%b exp=0", pixel_out_valid); end
    row_out++;
  endtask

  task automatic test_backpressure();
    logic acc, xf, orr;
    int cyc = 0, stall = 0, nintr = 0;
    nwin = 0;
    while (nwin < NWIN && cyc < 3000) begin
      orr = !(nwin == 100 && stall < 10);
      drive_cycle(pix_sent < 4 * W, orr, acc, xf);
      if (!orr) begin
        stall++;
        total++;
        if (pixel_out !== exp_win(row_out, 100, salt) || pixel_out_valid !== 1'b1) begin
          bad++; $display("FAIL bp_hold got=%h/%b exp=%h/1", pixel_out, pixel_out_valid, exp_win(row_out, 100, salt));
        end
      end
      if (out_intr) nintr++;
      if (xf) begin
        total++;
        if (pixel_out !== exp_win(row_out, nwin, salt)) begin
          bad++; $display("FAIL bp_win col=%0d got=%h exp=%h", nwin, pixel_out, exp_win(row_out, nwin, salt));
        end
        nwin++;
      end
      if (acc) pix_sent++;
      cyc++;
    end
    repeat (3) begin drive_cycle(1'b0, 1'b1, acc, xf); if (out_intr) nintr++; end
    total++; if (nwin != NWIN) begin bad++; $display("FAIL bp_count got=%0d exp=%0d", nwin, NWIN); end
    total++; if (stall != 10) begin bad++; $display("FAIL bp_stall got=%0d exp=10", stall); end
    total++; if (nintr != 1) begin bad++; $display("FAIL bp_intr got=%0d exp=1", nintr); end
    total++; if (dut.rd_lb !== 2'd2) begin bad++; $display("FAIL bp_rd_lb got=%0d exp=2", dut.rd_lb); end
    total++; if (fill_level !== 11'd512) begin bad++; $display("FAIL bp_fill got=%0d exp=512", fill_level); end
  endtask

  task automatic test_full();
    logic acc, xf;
    int nacc = 0;
    logic drop_seen = 1'b0;
    do_reset();
    salt = 8'h11;
    for (int i = 0; i < 1100; i++) begin
      drive_cycle(1'b1, 1'b0, acc, xf);
      if (!pixel_in_ready && !drop_seen) begin
        drop_seen = 1'b1;
        total++; if (fill_level !== 11'd1024) begin bad++; $display("FAIL full_drop_level got=%0d exp=1024", fill_level); end
      end
      if (acc) begin nacc++; pix_sent++; end
    end
    drive_cycle(1'b0, 1'b0, acc, xf);
    total++; if (drop_seen !== 1'b1) begin bad++; $display("FAIL full_drop got=%b exp=1", drop_seen); end
    total++; if (nacc != 1024) begin bad++; $display("FAIL full_accepted got=%0d exp=1024", nacc); end
    total++; if (fill_level !== 11'd1024) begin bad++; $display("FAIL full_fill got=%0d exp=1024", fill_level); end
    total++; if (dut.wr_lb !== 2'd0 || dut.wr_col !== 8'd0) begin bad++; $display("FAIL full_wr_ptr got=%0d/%0d exp=0/0", dut.wr_lb, dut.wr_col); end
    total++; if (pixel_out_valid !== 1'b1 || pixel_out !== exp_win(0, 0, salt)) begin
      bad++; $display("FAIL full_window got=%h/%b exp=%h/1", pixel_out, pixel_out_valid, exp_win(0, 0, salt));
    end
  endtask

  task automatic test_simultaneous();
    logic acc, xf;
    logic last_acc = 1'b0;
    int cyc = 0;
    do_reset();
    salt = 8'h3C;
    while (pix_sent < 900 && cyc < 2000) begin
      drive_cycle(1'b1, 1'b0, acc, xf);
      if (acc) pix_sent++;
      cyc++;
    end
    cyc = 0;
    while (nwin < NWIN && cyc < 1000) begin
      drive_cycle(nwin == NWIN - 1, 1'b1, acc, xf);
      if (xf) begin
        total++;
        if (pixel_out !== exp_win(0, nwin, salt)) begin
          bad++; $display("FAIL sim_win col=%0d got=%h exp=%h", nwin, pixel_out, exp_win(0, nwin, salt));
        end
        if (nwin == NWIN - 1) last_acc = acc;
        nwin++;
      end
      if (acc) pix_sent++;
      cyc++;
    end
    drive_cycle(1'b0, 1'b1, acc, xf);
    total++; if (last_acc !== 1'b1) begin bad++; $display("FAIL sim_accept got=%b exp=1", last_acc); end
    total++; if (fill_level !== 11'd645) begin bad++; $display("FAIL sim_fill got=%0d exp=645", fill_level); end
    total++; if (out_intr !== 1'b1) begin bad++; $display("FAIL sim_intr got=%b exp=1", out_intr); end
    total++; if (pixel_out_valid !== 1'b0) begin bad++; $display("FAIL sim_valid got=%b exp=0", pixel_out_valid); end
  endtask

  task automatic test_wrap();
    logic acc, xf;
    int cyc = 0, nintr = 0;
    do_reset();
    salt = 8'h00;
    while (row_out < 4 && cyc < 6000) begin
      drive_cycle(pix_sent < 6 * W, 1'b1, acc, xf);
      if (out_intr) nintr++;
      if (xf) begin
        total++;
        if (pixel_out !== exp_win(row_out, nwin, salt)) begin
          bad++; $display("FAIL wrap_win row=%0d col=%0d got=%h exp=%h", row_out, nwin, pixel_out, exp_win(row_out, nwin, salt));
        end
        nwin++;
        if (nwin == NWIN) begin nwin = 0; row_out++; end
      end
      if (acc) pix_sent++;
      cyc++;
    end
    repeat (3) begin drive_cycle(1'b0, 1'b1, acc, xf); if (out_intr) nintr++; end
    total++; if (row_out != 4) begin bad++; $display("FAIL wrap_rows got=%0d exp=4", row_out); end
    total++; if (nintr != 4) begin bad++; $display("FAIL wrap_intr got=%0d exp=4", nintr); end
    total++; if (dut.rd_lb !== 2'd0) begin bad++; $display("FAIL wrap_rd_lb got=%0d exp=0", dut.rd_lb); end
    total++; if (fill_level !== 11'd512) begin bad++; $display("FAIL wrap_fill got=%0d exp=512", fill_level); end
  endtask

  task automatic test_reset_mid();
    logic acc, xf;
    int cyc = 0;
    do_reset();
    salt = 8'h00;
    while (pix_sent < 4 * W + 100 && cyc < 6000) begin
      drive_cycle(1'b1, 1'b1, acc, xf);
      if (xf) begin
        total++;
        if (pixel_out !== exp_win(row_out, nwin, salt)) begin
          bad++; $display("FAIL mid_win row=%0d col=%0d got=%h exp=%h", row_out, nwin, pixel_out, exp_win(row_out, nwin, salt));
        end
        nwin++;
        if (nwin == NWIN) begin nwin = 0; row_out++; end
      end
      if (acc) pix_sent++;
      cyc++;
    end
    @(negedge clk);
    pixel_in_valid = 1'b0;
    rst = 1'b0;
    #1;
    total++; if (pixel_out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b exp=0", pixel_out_valid); end
    total++; if (out_intr !== 1'b0) begin bad++; $display("FAIL mid_rst_intr got=%b exp=0", out_intr); end
    total++; if (pixel_out !== '0) begin bad++; $display("FAIL mid_rst_out got=%h exp=0", pixel_out); end
    total++; if (fill_level !== 11'd0) begin bad++; $display("FAIL mid_rst_fill got=%0d exp=0", fill_level); end
    total++; if (pixel_in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready got=%b exp=1", pixel_in_ready); end
    total++; if (dut.wr_col !== 8'd0 || dut.wr_lb !== 2'd0 || dut.rd_lb !== 2'd0 || dut.rd_col !== 8'd0) begin
      bad++; $display("FAIL mid_rst_ptrs got=%0d/%0d/%0d/%0d exp=0/0/0/0", dut.wr_lb, dut.wr_col, dut.rd_lb, dut.rd_col);
    end
    @(negedge clk);
    rst = 1'b1;
    pix_sent = 0; row_out = 0; nwin = 0; salt = 8'h5A; cyc = 0;
    while (nwin < NWIN && cyc < 3000) begin
      drive_cycle(pix_sent < 3 * W, 1'b1, acc, xf);
      if (xf) begin
        total++;
        if (pixel_out !== exp_win(0, nwin, salt)) begin
          bad++; $display("FAIL mid_new_win col=%0d got=%h exp=%h", nwin, pixel_out, exp_win(0, nwin, salt));
        end
        nwin++;
      end
      if (acc) pix_sent++;
      cyc++;
    end
    total++; if (nwin != NWIN) begin bad++; $display("FAIL mid_new_count got=%0d exp=%0d", nwin, NWIN); end
  endtask

  task automatic test_sweep();
    logic sacc, sx;
    int sn = 0, nw = 0, nintr = 0, cyc = 0;
    do_reset();
    while (nw < 12 && cyc < 500) begin
      @(negedge clk);
      s_pixel_in  = sval(sn);
      s_in_valid  = (sn < 80);
      s_out_ready = 1'b1;
      sacc = s_in_valid && s_in_ready;
      sx   = s_out_valid && s_out_ready;
      if (s_intr) nintr++;
      if (sx) begin
        if (nw == 0) begin
          total++;
          if (s_pixel_out[249:240] !== 10'd161 || s_pixel_out[9:0] !== 10'd1) begin
            bad++; $display("FAIL sweep_corners got=%0d/%0d exp=161/1", s_pixel_out[249:240], s_pixel_out[9:0]);
          end
        end
        total++;
        if (s_pixel_out !== exp_swin(nw)) begin
          bad++; $display("FAIL sweep_win col=%0d got=%h exp=%h", nw, s_pixel_out, exp_swin(nw));
        end
        nw++;
      end
      if (sacc) sn++;
      cyc++;
    end
    s_in_valid = 1'b0;
    repeat (3) begin @(negedge clk); if (s_intr) nintr++; end
    total++; if (nw != 12) begin bad++; $display("FAIL sweep_count got=%0d exp=12", nw); end
    total++; if (nintr != 1) begin bad++; $display("FAIL sweep_intr got=%0d exp=1", nintr); end
    total++; if (s_fill !== 7'd64) begin bad++; $display("FAIL sweep_fill got=%0d exp=64", s_fill); end
    total++; if (s_out_valid !== 1'b0) begin bad++; $display("FAIL sweep_valid got=%b exp=0", s_out_valid); end
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_backpressure();
    test_full();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_window_ctrl.md
LINE_WINDOW_CTRL -- requirements
Module: line_window_ctrl

Interface
REQ-001 The block SHALL have parameter PIXEL_W, default 8, meaning bits per pixel.
REQ-002 The block SHALL have parameter IMG_WIDTH, default 256, meaning pixels per image row; legal range KERNEL..4096.
REQ-003 The block SHALL have parameter KERNEL, default 3, meaning window height and width; odd, 3 or larger.
REQ-004 The block SHALL have derived localparams NUM_LB = KERNEL+1 and CAP = NUM_LB*IMG_WIDTH.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port pixel_in, input, PIXEL_W bits: incoming raster pixel.
REQ-008 The block SHALL have port pixel_in_valid, input, 1 bit: pixel_in is valid.
REQ-009 The block SHALL have port pixel_in_ready, output, 1 bit: a pixel is accepted when pixel_in_valid and pixel_in_ready are both high.
REQ-010 The block SHALL have port pixel_out, output, KERNEL*KERNEL*PIXEL_W bits: the KERNEL x KERNEL window.
REQ-011 The block SHALL have port pixel_out_valid, output, 1 bit: pixel_out holds a window.
REQ-012 The block SHALL have port pixel_out_ready, input, 1 bit: a window transfers when pixel_out_valid and pixel_out_ready are both high.
REQ-013 The block SHALL have port out_intr, output, 1 bit: one-cycle pulse when an output row completes.
REQ-014 The block SHALL have port fill_level, output, clog2(CAP+1) bits: number of stored, unreleased pixels.

Function
REQ-015 The block SHALL store pixels in NUM_LB internal line memories, each IMG_WIDTH x PIXEL_W, forming a ring.
REQ-016 The block SHALL write each accepted pixel to line wr_lb at column wr_col.
- wr_col wraps from IMG_WIDTH-1 to 0.
- On that wrap, wr_lb increments modulo NUM_LB.
REQ-017 The block SHALL drive pixel_in_ready combinationally as (fill_level < CAP), so unreleased lines are never overwritten.
REQ-018 The block SHALL increase fill_level by 1 per accepted pixel and decrease it by IMG_WIDTH per row release.
- When both happen in the same cycle, fill_level SHALL become fill_level + 1 - IMG_WIDTH.
REQ-019 The read side SHALL be a state machine with states IDLE, LOAD and READ.
- IDLE to LOAD when fill_level >= KERNEL*IMG_WIDTH.
- LOAD to READ after exactly one cycle.
- READ to IDLE on transfer of the last window of the row.
REQ-020 In LOAD, the block SHALL fetch the window at rd_col = 0; pixel_out_valid SHALL rise on the first READ cycle, so first-window latency is 2 cycles from leaving IDLE.
REQ-021 Per row, the block SHALL emit IMG_WIDTH-KERNEL+1 windows, for rd_col = 0 .. IMG_WIDTH-KERNEL, with no padding.
- On each transfer the next window SHALL be presented the following cycle with valid held high, giving one window per cycle when pixel_out_ready is held high.
REQ-022 Window layout SHALL be as follows.
- Row k (k = 0..KERNEL-1) comes from line (rd_lb+k) mod NUM_LB.
- Row 0 is the oldest line, in the least significant row slice.
- Within a row, column rd_col+j occupies bits [(k*KERNEL+j)*PIXEL_W +: PIXEL_W].
REQ-023 While pixel_out_valid is high and pixel_out_ready is low, pixel_out SHALL remain stable and no window SHALL be skipped or duplicated.
REQ-024 On the last-window transfer, in the same cycle:
- rd_lb SHALL increment modulo NUM_LB;
- the row release SHALL apply to fill_level;
- out_intr SHALL pulse high for exactly one cycle;
- pixel_out_valid SHALL fall, unless re-asserted through LOAD.
REQ-025 Writes and reads SHALL proceed concurrently; pixel acceptance SHALL NOT depend on the read state beyond REQ-017.
REQ-026 Pixels presented while pixel_in_ready is low SHALL be ignored, and all write pointers SHALL be unchanged.

Reset
REQ-027 While rst is low, the block SHALL hold the following values regardless of clk.
- Read state = IDLE.
- wr_lb, wr_col, rd_lb, rd_col and fill_level = 0.
- pixel_out_valid = 0, out_intr = 0, pixel_out = 0.
- pixel_in_ready = 1.
REQ-028 Line memory contents SHALL NOT be cleared by reset; after reset they are don't-care and never emitted before being rewritten.
REQ-029 Reset asserted mid-row SHALL discard all partial lines and windows; streaming after release SHALL restart at row 0, column 0.

Verification (defaults PIXEL_W=8, IMG_WIDTH=256, KERNEL=3 unless stated)
REQ-030 Basic fill: stream 768 pixels, value = (row*16+col) mod 256, ready high.
- pixel_out_valid rises 2 cycles after fill_level reaches 768.
- First window is rows 0..2, cols 0..2; exactly 254 windows are emitted.
- out_intr pulses once; fill_level ends at 512.
REQ-031 Backpressure: drop pixel_out_ready for 10 cycles mid-row.
- pixel_out is constant throughout.
- The 254 windows are still delivered in order, with no gaps or repeats.
REQ-032 Full: hold pixel_out_ready low and stream 1100 pixels.
- pixel_in_ready falls at fill_level = 1024.
- Pixels 1025 onward are not accepted; wr_lb = 0, wr_col = 0.
REQ-033 Simultaneous event: accept a pixel on the cycle of the last-window transfer with fill_level = 900 -> fill_level = 645.
REQ-034 Wrap and reset: stream 6 rows and check windows for rows 3..5 after rd_lb wraps 3 -> 0.
- Assert rst for 1 cycle mid-row 4; all outputs take their REQ-027 values immediately.
- The next 768 pixels yield windows from the new data only.
REQ-035 Parameter sweep: KERNEL=5, IMG_WIDTH=16, PIXEL_W=10.
- 12 windows per row; pixel_out width = 250.
- Layout per REQ-022.
